// File: rtl/clock_pkg.sv
// clock_pkg: shared encodings for the wall-clock time-set logic.
//   state_e  : time_set_ctrl FSM states (RUN = 0 .. SET_SEG = 3)
//   field_e  : selected-field codes driven on `field` (NONE, HORA, MIN, SEG)
//   MS_CNT_W : width of every millisecond counter
package clock_pkg;

    localparam int unsigned MS_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HORA = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEG  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        HORA = 2'd1,
        MIN  = 2'd2,
        SEG  = 2'd3
    } field_e;

    // Mode button walks RUN -> SET_HORA -> SET_MIN -> SET_SEG -> RUN.
    function automatic state_e next_state(input state_e s);
        case (s)
            RUN:      return SET_HORA;
            SET_HORA: return SET_MIN;
            SET_MIN:  return SET_SEG;
            default:  return RUN;
        endcase
    endfunction

    function automatic field_e field_of(input state_e s);
        case (s)
            SET_HORA: return HORA;
            SET_MIN:  return MIN;
            SET_SEG:  return SEG;
            default:  return NONE;
        endcase
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: button front end / counter side bundle of time_set_ctrl.
//   master : drives tick_1ms and the debounced button levels, observes outputs
//   slave  : time_set_ctrl itself (run_en, field, adjust strobes, blink)
interface time_set_ctrl_if;

    logic       tick_1ms;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;

    logic       run_en;
    logic [1:0] field;
    logic       up_hora;
    logic       down_hora;
    logic       up_min;
    logic       down_min;
    logic       up_seg;
    logic       down_seg;
    logic       blink;

    modport master (
        output tick_1ms, btn_mode, btn_up, btn_down,
        input  run_en, field, up_hora, down_hora, up_min, down_min, up_seg, down_seg, blink
    );

    modport slave (
        input  tick_1ms, btn_mode, btn_up, btn_down,
        output run_en, field, up_hora, down_hora, up_min, down_min, up_seg, down_seg, blink
    );

endinterface

// File: rtl/btn_repeat.sv
// btn_repeat: rising-edge detector with optional hold/auto-repeat for one button.
//   clk, reset : clock, asynchronous active-high reset
//   level      : debounced button level
//   tick       : 1 ms strobe
//   clear      : restarts the hold/repeat sequence
//   strobe     : combinational request (rising edge, or repeat on the threshold tick)
// Optional feature: TIME_SET_AUTO_REPEAT_EN adds the hold/repeat counter.
module btn_repeat
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_MS   = 500,
    parameter int unsigned REPEAT_MS = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic tick,
    input  logic clear,
    output logic strobe
);

    logic level_q;
    logic rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam logic [MS_CNT_W-1:0] HoldLast   = MS_CNT_W'(HOLD_MS - 1);
    localparam logic [MS_CNT_W-1:0] RepeatLast = MS_CNT_W'(REPEAT_MS - 1);

    logic [MS_CNT_W-1:0] hold_cnt_q;
    logic                repeating_q;  // first threshold passed, now on REPEAT_MS period
    logic                rep_fire;

    assign rep_fire = tick & level & ~clear &
                      (hold_cnt_q == (repeating_q ? RepeatLast : HoldLast));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q  <= '0;
            repeating_q <= 1'b0;
        end else if (!level || clear) begin
            hold_cnt_q  <= '0;
            repeating_q <= 1'b0;
        end else if (tick) begin
            if (rep_fire) begin
                hold_cnt_q  <= '0;
                repeating_q <= 1'b1;
            end else begin
                hold_cnt_q <= hold_cnt_q + MS_CNT_W'(1);
            end
        end
    end

    assign strobe = rise | rep_fire;
`else
    logic unused_cfg;
    assign unused_cfg = ^{tick, clear, HOLD_MS, REPEAT_MS};
    assign strobe     = rise;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: mode/adjust controller for the hora/min/seg counters.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : time_set_ctrl_if.slave
//                in : tick_1ms, btn_mode, btn_up, btn_down
//                out: run_en, field, up_/down_ hora/min/seg strobes, blink
// All outputs are registered. TIME_SET_AUTO_REPEAT_EN enables hold/auto-repeat
// in the btn_repeat instances.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_MS    = 500,
    parameter int unsigned REPEAT_MS  = 100,
    parameter int unsigned TIMEOUT_MS = 10000,
    parameter int unsigned BLINK_MS   = 250
) (
    input  logic           clk,
    input  logic           reset,
    time_set_ctrl_if.slave bus
);

    localparam logic [MS_CNT_W-1:0] TimeoutLast = MS_CNT_W'(TIMEOUT_MS - 1);
    localparam logic [MS_CNT_W-1:0] BlinkLast   = MS_CNT_W'(BLINK_MS - 1);

    state_e              state_q;
    field_e              field_q;
    logic                run_en_q;
    logic                blink_q;
    logic                mode_q;
    logic [MS_CNT_W-1:0] to_cnt_q;
    logic [MS_CNT_W-1:0] blink_cnt_q;
    logic                up_hora_q, down_hora_q;
    logic                up_min_q, down_min_q;
    logic                up_seg_q, down_seg_q;

    logic in_set;
    logic mode_rise;
    logic both;
    logic rep_clear;
    logic any_btn;
    logic up_raw, down_raw;
    logic up_fire, down_fire;
    logic timeout_hit;

    always_comb begin
        in_set    = (state_q != RUN);
        mode_rise = bus.btn_mode & ~mode_q;
        both      = bus.btn_up & bus.btn_down;
        any_btn   = bus.btn_mode | bus.btn_up | bus.btn_down;
        // Hold counters restart on mode change, on up+down, and stay idle in RUN.
        rep_clear = mode_rise | both | ~in_set;
        // Mode edge wins over up/down; up+down together adjusts nothing.
        up_fire   = in_set & ~mode_rise & ~both & up_raw;
        down_fire = in_set & ~mode_rise & ~both & down_raw;
        // Any button level keeps to_cnt at zero, so this cannot coincide with a strobe.
        timeout_hit = in_set & bus.tick_1ms & ~any_btn & (to_cnt_q == TimeoutLast);
    end

    btn_repeat #(
        .HOLD_MS   (HOLD_MS),
        .REPEAT_MS (REPEAT_MS)
    ) u_up (
        .clk    (clk),
        .reset  (reset),
        .level  (bus.btn_up),
        .tick   (bus.tick_1ms),
        .clear  (rep_clear),
        .strobe (up_raw)
    );

    btn_repeat #(
        .HOLD_MS   (HOLD_MS),
        .REPEAT_MS (REPEAT_MS)
    ) u_down (
        .clk    (clk),
        .reset  (reset),
        .level  (bus.btn_down),
        .tick   (bus.tick_1ms),
        .clear  (rep_clear),
        .strobe (down_raw)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            field_q     <= NONE;
            run_en_q    <= 1'b1;
            blink_q     <= 1'b0;
            mode_q      <= 1'b0;
            to_cnt_q    <= '0;
            blink_cnt_q <= '0;
            up_hora_q   <= 1'b0;
            down_hora_q <= 1'b0;
            up_min_q    <= 1'b0;
            down_min_q  <= 1'b0;
            up_seg_q    <= 1'b0;
            down_seg_q  <= 1'b0;
        end else begin
            mode_q <= bus.btn_mode;

            up_hora_q   <= up_fire   && (state_q == SET_HORA);
            down_hora_q <= down_fire && (state_q == SET_HORA);
            up_min_q    <= up_fire   && (state_q == SET_MIN);
            down_min_q  <= down_fire && (state_q == SET_MIN);
            up_seg_q    <= up_fire   && (state_q == SET_SEG);
            down_seg_q  <= down_fire && (state_q == SET_SEG);

            if (mode_rise) begin
                state_q     <= next_state(state_q);
                field_q     <= field_of(next_state(state_q));
                run_en_q    <= (next_state(state_q) == RUN);
                blink_q     <= 1'b0;
                blink_cnt_q <= '0;
                to_cnt_q    <= '0;
            end else if (timeout_hit) begin
                state_q     <= RUN;
                field_q     <= NONE;
                run_en_q    <= 1'b1;
                blink_q     <= 1'b0;
                blink_cnt_q <= '0;
                to_cnt_q    <= '0;
            end else if (in_set) begin
                if (any_btn) begin
                    to_cnt_q <= '0;
                end else if (bus.tick_1ms) begin
                    to_cnt_q <= to_cnt_q + MS_CNT_W'(1);
                end

                // Keep the field visible while it is being adjusted.
                if (up_fire || down_fire) begin
                    blink_q     <= 1'b0;
                    blink_cnt_q <= '0;
                end else if (bus.tick_1ms) begin
                    if (blink_cnt_q == BlinkLast) begin
                        blink_q     <= ~blink_q;
                        blink_cnt_q <= '0;
                    end else begin
                        blink_cnt_q <= blink_cnt_q + MS_CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.run_en    = run_en_q;
    assign bus.field     = field_q;
    assign bus.blink     = blink_q;
    assign bus.up_hora   = up_hora_q;
    assign bus.down_hora = down_hora_q;
    assign bus.up_min    = up_min_q;
    assign bus.down_min  = down_min_q;
    assign bus.up_seg    = up_seg_q;
    assign bus.down_seg  = down_seg_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: HOLD_MS=4, REPEAT_MS=2, TIMEOUT_MS=20, BLINK_MS=3,
// tick_1ms once every 10 clocks. Outputs are sampled 1 time unit after posedge.
module tb_time_set_ctrl;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   phase    = 0;
    int   ticks    = 0;

    time_set_ctrl_if bus();

    time_set_ctrl #(
        .HOLD_MS    (4),
        .REPEAT_MS  (2),
        .TIMEOUT_MS (20),
        .BLINK_MS   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {up_hora, down_hora, up_min, down_min, up_seg, down_seg}
    logic [5:0] stb;
    assign stb = {bus.up_hora, bus.down_hora, bus.up_min, bus.down_min, bus.up_seg,
                  bus.down_seg};

    // One clock; tick_1ms is high in every tenth call.
    task automatic cyc();
        bus.tick_1ms = (phase == 9);
        @(posedge clk);
        #1;
        if (phase == 9) begin
            phase = 0;
            ticks++;
        end else begin
            phase++;
        end
        bus.tick_1ms = 1'b0;
    endtask

    task automatic align();
        while (phase != 0) cyc();
    endtask

    task automatic run_ticks(input int k);
        int target;
        target = ticks + k;
        while (ticks < target) cyc();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic mode_pulse();
        bus.btn_mode = 1'b1;
        cyc();
        bus.btn_mode = 1'b0;
        cyc();
    endtask

    task automatic goto_state(input int n);
        do_reset();
        align();
        repeat (n) mode_pulse();
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.tick_1ms = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        cyc();
        checks++;
        if (bus.run_en !== 1'b1) begin
            failures++; $display("FAIL reset_run_en: got %b expected 1", bus.run_en);
        end
        checks++;
        if (bus.field !== 2'd0) begin
            failures++; $display("FAIL reset_field: got %0d expected 0", bus.field);
        end
        checks++;
        if (stb !== 6'b0) begin
            failures++; $display("FAIL reset_strobes: got %b expected 000000", stb);
        end
        checks++;
        if (bus.blink !== 1'b0) begin
            failures++; $display("FAIL reset_blink: got %b expected 0", bus.blink);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_field [4];
        logic       exp_run   [4];
        exp_field = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_run   = '{1'b0, 1'b0, 1'b0, 1'b1};
        align();
        for (int i = 0; i < 4; i++) begin
            bus.btn_mode = 1'b1;
            cyc();
            checks++;
            if (bus.field !== exp_field[i] || bus.run_en !== exp_run[i]) begin
                failures++;
                $display("FAIL mode_step%0d: got field=%0d run_en=%b expected field=%0d run_en=%b",
                         i, bus.field, bus.run_en, exp_field[i], exp_run[i]);
            end
            bus.btn_mode = 1'b0;
            cyc();
        end
    endtask

    task automatic test_edge_strobe();
        int bad;
        goto_state(2);
        bus.btn_up = 1'b1;
        cyc();
        checks++;
        if (stb !== 6'b001000) begin
            failures++; $display("FAIL edge_up_min: got %b expected 001000", stb);
        end
        cyc();
        checks++;
        if (stb !== 6'b000000) begin
            failures++; $display("FAIL edge_single_cycle: got %b expected 000000", stb);
        end
        bus.btn_up = 1'b0;
        cyc();
        mode_pulse();
        mode_pulse();
        checks++;
        if (bus.run_en !== 1'b1) begin
            failures++; $display("FAIL edge_back_to_run: got %b expected 1", bus.run_en);
        end
        bad = 0;
        bus.btn_up = 1'b1;
        repeat (2) begin
            cyc();
            if (stb !== 6'b0) bad++;
        end
        bus.btn_up = 1'b0;
        cyc();
        if (stb !== 6'b0) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL run_ignores_up: got %0d strobe cycles expected 0", bad);
        end
    endtask

    task automatic test_auto_repeat();
        int cnt;
        int other;
        int exp_cnt;
        logic exp40;
`ifdef TIME_SET_AUTO_REPEAT_EN
        exp_cnt = 5;
        exp40   = 1'b1;
`else
        exp_cnt = 1;
        exp40   = 1'b0;
`endif
        goto_state(3);
        align();
        cnt   = 0;
        other = 0;
        bus.btn_down = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            cyc();
            if (stb[0] === 1'b1) cnt++;
            if ((stb & 6'b111110) !== 6'b0) other++;
            if (c == 1) begin
                checks++;
                if (stb !== 6'b000001) begin
                    failures++; $display("FAIL repeat_edge: got %b expected 000001", stb);
                end
            end
            if (c == 40) begin
                checks++;
                if (stb[0] !== exp40) begin
                    failures++; $display("FAIL repeat_tick4: got %b expected %b", stb[0], exp40);
                end
            end
        end
        bus.btn_down = 1'b0;
        repeat (3) begin
            cyc();
            if (stb[0] === 1'b1) cnt++;
            if ((stb & 6'b111110) !== 6'b0) other++;
        end
        checks++;
        if (cnt != exp_cnt) begin
            failures++; $display("FAIL repeat_count: got %0d expected %0d", cnt, exp_cnt);
        end
        checks++;
        if (other != 0) begin
            failures++; $display("FAIL repeat_other: got %0d expected 0", other);
        end
    endtask

    task automatic test_conflicts();
        int bad;
        goto_state(1);
        align();
        bad = 0;
        bus.btn_up   = 1'b1;
        bus.btn_down = 1'b1;
        repeat (60) begin
            cyc();
            if (stb !== 6'b0) bad++;
        end
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        cyc();
        if (stb !== 6'b0) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL both_pressed: got %0d strobe cycles expected 0", bad);
        end
        bus.btn_mode = 1'b1;
        bus.btn_up   = 1'b1;
        cyc();
        checks++;
        if (bus.field !== 2'd2 || stb !== 6'b0) begin
            failures++;
            $display("FAIL mode_wins: got field=%0d strobes=%b expected field=2 strobes=000000",
                     bus.field, stb);
        end
        bus.btn_mode = 1'b0;
        cyc();
        checks++;
        if (stb !== 6'b0) begin
            failures++; $display("FAIL mode_wins_late: got %b expected 000000", stb);
        end
        bus.btn_up = 1'b0;
        cyc();
    endtask

    task automatic test_blink_timeout();
        goto_state(2);
        run_ticks(2);
        checks++;
        if (bus.blink !== 1'b0) begin
            failures++; $display("FAIL blink_t2: got %b expected 0", bus.blink);
        end
        run_ticks(1);
        checks++;
        if (bus.blink !== 1'b1) begin
            failures++; $display("FAIL blink_t3: got %b expected 1", bus.blink);
        end
        run_ticks(3);
        checks++;
        if (bus.blink !== 1'b0) begin
            failures++; $display("FAIL blink_t6: got %b expected 0", bus.blink);
        end
        run_ticks(13);
        checks++;
        if (bus.field !== 2'd2 || bus.run_en !== 1'b0) begin
            failures++;
            $display("FAIL timeout_t19: got field=%0d run_en=%b expected field=2 run_en=0",
                     bus.field, bus.run_en);
        end
        run_ticks(1);
        checks++;
        if (bus.field !== 2'd0 || bus.run_en !== 1'b1 || bus.blink !== 1'b0) begin
            failures++;
            $display("FAIL timeout_t20: got field=%0d run_en=%b blink=%b expected 0 1 0",
                     bus.field, bus.run_en, bus.blink);
        end

        goto_state(2);
        run_ticks(15);
        checks++;
        if (bus.blink !== 1'b1) begin
            failures++; $display("FAIL blink_t15: got %b expected 1", bus.blink);
        end
        bus.btn_up = 1'b1;
        cyc();
        checks++;
        if (stb !== 6'b001000 || bus.blink !== 1'b0) begin
            failures++;
            $display("FAIL adjust_blink: got strobes=%b blink=%b expected 001000 0", stb, bus.blink);
        end
        bus.btn_up = 1'b0;
        cyc();
        run_ticks(19);
        checks++;
        if (bus.field !== 2'd2) begin
            failures++; $display("FAIL timeout_restart_19: got field=%0d expected 2", bus.field);
        end
        run_ticks(1);
        checks++;
        if (bus.field !== 2'd0 || bus.run_en !== 1'b1) begin
            failures++;
            $display("FAIL timeout_restart_20: got field=%0d run_en=%b expected 0 1",
                     bus.field, bus.run_en);
        end
    endtask

    task automatic test_reset_midstrobe();
        int bad;
        goto_state(3);
        bus.btn_up = 1'b1;
        cyc();
        checks++;
        if (stb !== 6'b000010) begin
            failures++; $display("FAIL pre_reset_up_seg: got %b expected 000010", stb);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (stb !== 6'b0 || bus.field !== 2'd0 || bus.run_en !== 1'b1 || bus.blink !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got strobes=%b field=%0d run_en=%b blink=%b expected 0 0 1 0",
                     stb, bus.field, bus.run_en, bus.blink);
        end
        cyc();
        cyc();
        reset = 1'b0;
        bad = 0;
        repeat (2) begin
            cyc();
            if (stb !== 6'b0) bad++;
        end
        bus.btn_mode = 1'b1;
        cyc();
        if (stb !== 6'b0) bad++;
        bus.btn_mode = 1'b0;
        repeat (4) begin
            cyc();
            if (stb !== 6'b0) bad++;
        end
        checks++;
        if (bus.field !== 2'd1) begin
            failures++; $display("FAIL post_reset_field: got %0d expected 1", bus.field);
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL held_through_reset: got %0d strobe cycles expected 0", bad);
        end
        bus.btn_up = 1'b0;
        cyc();
        bus.btn_up = 1'b1;
        cyc();
        checks++;
        if (stb !== 6'b100000) begin
            failures++; $display("FAIL repress_up_hora: got %b expected 100000", stb);
        end
        bus.btn_up = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_edge_strobe();
        test_auto_repeat();
        test_conflicts();
        test_blink_timeout();
        test_reset_midstrobe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Mode and adjustment controller for the wall-clock time counters. It turns debounced mode/up/down buttons into single-cycle `up_*`/`down_*` strobes for the hours, minutes and seconds counters and gates normal counting while a field is being set. It also provides a blink enable for the display and an inactivity timeout back to run mode. It sits between the button front end and the `hora`/`min`/`seg` counter blocks and is timed by the shared 1 ms strobe.

## Interface
- `HOLD_MS`, 500: ms a button must be held before auto-repeat starts.
- `REPEAT_MS`, 100: ms between auto-repeat strobes.
- `TIMEOUT_MS`, 10000: ms with no button activity before returning to RUN. Must be < 65536.
- `BLINK_MS`, 250: half-period of `blink`, in ms.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `tick_1ms` in 1: single-cycle strobe, once per ms.
- `btn_mode` in 1: debounced level, synchronous to `clk`.
- `btn_up` in 1: debounced level, synchronous to `clk`.
- `btn_down` in 1: debounced level, synchronous to `clk`.
- `run_en` out 1: high only in RUN; gates the counters' normal tick.
- `field` out 2: 0 = none, 1 = hora, 2 = min, 3 = seg.
- `up_hora`, `down_hora`, `up_min`, `down_min`, `up_seg`, `down_seg` out 1 each: single-cycle adjust strobes.
- `blink` out 1: display blank enable for the selected field.

## Operation
- FSM states: RUN, SET_HORA, SET_MIN, SET_SEG.
- A `btn_mode` rising edge advances RUN → SET_HORA → SET_MIN → SET_SEG → RUN.
- Rising edge of a button = current level high and previous-cycle registered level low.
- In RUN:
  - up/down are ignored;
  - all strobes are 0;
  - `field` = 0 and `blink` = 0.
- In a SET state:
  - A `btn_up` rising edge emits one up strobe to the selected field.
  - A `btn_down` rising edge emits one down strobe to the selected field.
- Priorities and conflicts:
  - `btn_mode` edge in the same cycle as an up/down edge: mode wins and the up/down edge is discarded.
  - `btn_up` and `btn_down` both high: no strobes, and the hold counters clear.
- Auto-repeat (see Configuration):
  - The hold counter counts `tick_1ms` while exactly one of up/down is held.
  - After `HOLD_MS` ticks, one strobe is emitted; afterwards one strobe every `REPEAT_MS` ticks.
  - Release, a mode change, or both buttons pressed clears the counter.
- Timeout:
  - In SET states a 16-bit counter counts `tick_1ms`.
  - Any button level high clears it.
  - Reaching `TIMEOUT_MS` forces RUN.
  - It does not count in RUN.
- Blink:
  - In SET states a counter toggles `blink` every `BLINK_MS` ticks.
  - Entering a SET state sets `blink` = 0 and clears the counter.
  - Any adjust strobe also forces `blink` = 0 and restarts the counter, so the value stays visible while adjusting.
- Strobes are mutually exclusive: at most one `up_*`/`down_*` is high per cycle.

## Timing
- Reset values (asynchronous): state = RUN, `run_en` = 1, `field` = 0, all strobes 0, `blink` = 0, all counters 0, edge registers 0.
- All outputs are registered.
- Edge-initiated strobe: high the cycle after the button's first high sample, for exactly one cycle.
- Mode edge: state, `field` and `run_en` update the cycle after the edge.
- Auto-repeat strobe: high the cycle after the `tick_1ms` that reaches the threshold.
- Timeout: RUN is entered the cycle after the `tick_1ms` that reaches `TIMEOUT_MS`.
- Reset mid-operation: immediate return to reset values. A strobe in flight is dropped, not completed.
- A button held through reset deassertion produces no edge until it is released and pressed again, because the edge register samples the level from the first post-reset cycle.

## Configuration
- `TIME_SET_AUTO_REPEAT_EN` defined: hold and repeat counters present; behaviour as above.
- Not defined: hold/repeat logic is removed. Only rising edges produce strobes, and `HOLD_MS`/`REPEAT_MS` are unused.

## Structure
- Shared package `clock_pkg`:
  - state encoding (RUN = 0, SET_HORA = 1, SET_MIN = 2, SET_SEG = 3);
  - field codes (NONE, HORA, MIN, SEG);
  - `MS_CNT_W` = 16.
- One sub-module `btn_repeat`, instantiated twice (up, down):
  - inputs: level, tick, clear;
  - outputs: edge/repeat strobe;
  - contains the edge register and the `ifdef`'d hold/repeat counter.

## Test plan
Bench parameters: `HOLD_MS` = 4, `REPEAT_MS` = 2, `TIMEOUT_MS` = 20, `BLINK_MS` = 3, `tick_1ms` every 10 cycles.

1. Reset, then three `btn_mode` pulses → `field` steps 1, 2, 3, each the cycle after its edge with `run_en` = 0. Fourth pulse → `field` = 0, `run_en` = 1.
2. SET_MIN with a 2-cycle `btn_up` pulse → exactly one `up_min` cycle, the cycle after the rise; no other strobe. Same `btn_up` pulse in RUN → no strobes.
3. SET_SEG with `btn_down` held for 10 ticks, `AUTO_REPEAT_EN` defined → `down_seg` at the edge, then after tick 4, 6, 8 and 10 (5 strobes total). With the macro undefined → 1 strobe.
4. SET_HORA with `btn_up` and `btn_down` rising in the same cycle → no strobes. `btn_mode` and `btn_up` rising together → state advances to SET_MIN, no `up_hora`.
5. SET_MIN left idle → `blink` toggles every 3 ticks; after tick 20, state = RUN and `blink` = 0. Pressing `btn_up` at tick 15 restarts the timeout from that point.
6. `reset` asserted in SET_SEG mid-strobe with `btn_up` held → outputs return to reset values immediately. After release, no `up_*` strobe until `btn_up` falls and rises again.
